// File: rtl/fixed_div_pkg.sv
// fixed_div_pkg: shared types and default configuration for the iterative
// signed fixed-point divider (fixed_divider / div_core).
//   - state_e    : divider FSM states
//   - M_DEF/FRAC_DEF : default operand width and fractional bits (Q4.28)
//   - N, CNT_W   : iteration count (quotient width) and step-counter width
//   - MAX_POS/MAX_NEG : saturation / divide-by-zero limits at the default width
package fixed_div_pkg;

  localparam int M_DEF    = 32;
  localparam int FRAC_DEF = 28;
  localparam int N        = M_DEF + FRAC_DEF;
  localparam int CNT_W    = $clog2(N);

  localparam logic [M_DEF-1:0] MAX_POS = {1'b0, {(M_DEF-1){1'b1}}};
  localparam logic [M_DEF-1:0] MAX_NEG = {1'b1, {(M_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_ZERO = 2'd3
  } state_e;

endpackage

// File: rtl/fixed_divider_div_core.sv
// div_core: unsigned restoring divider datapath, one quotient bit per step.
// The quotient register starts out holding the dividend; each step shifts the
// dividend MSB into the partial remainder and the new quotient bit into the LSB,
// so after N steps it holds the full N-bit quotient.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   load        capture dividend/divisor, clear remainder, cnt = N-1
//   step        perform one restoring iteration (caller gates with ce)
//   dividend    N-bit unsigned dividend (|a| << FRAC)
//   divisor     M-bit unsigned divisor (|b|, non-zero)
//   quotient    N-bit unsigned quotient
//   last        high while the pending step is the final one (cnt == 0)
module div_core #(
  parameter int M     = 32,
  parameter int N     = 60,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [N-1:0]     dividend,
  input  logic [M-1:0]     divisor,
  output logic [N-1:0]     quotient,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [M-1:0]     rem_r;
  logic [M-1:0]     div_r;
  logic [N-1:0]     q_r;
  logic [CNT_W-1:0] cnt_r;

  logic [M:0]       trial_s;
  logic             ge_s;
  logic [M-1:0]     rem_next_s;

  // One restoring iteration: the remainder stays below the divisor, so M bits
  // suffice for storage while the trial value needs M+1.
  always_comb begin
    trial_s = {rem_r, q_r[N-1]};
    ge_s    = (trial_s >= {1'b0, div_r});
    if (ge_s) begin
      rem_next_s = M'(trial_s - {1'b0, div_r});
    end else begin
      rem_next_s = trial_s[M-1:0];
    end
  end

  // Datapath registers: load on accept, advance one bit per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r <= {M{1'b0}};
      div_r <= {M{1'b0}};
      q_r   <= {N{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      rem_r <= {M{1'b0}};
      div_r <= divisor;
      q_r   <= dividend;
      cnt_r <= CNT_INIT;
    end else if (step) begin
      rem_r <= rem_next_s;
      q_r   <= {q_r[N-2:0], ge_s};
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  assign quotient = q_r;
  assign last     = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/fixed_divider.sv
// fixed_divider: iterative signed fixed-point divider,
//   result = (a << FRAC) / b, truncated toward zero, one quotient bit per ce cycle.
// Shares the ce/start -> valid handshake of the fractal ALU multiplier.
// Ports:
//   clk, rst_n    clock / async active-low reset
//   ce            clock enable; FSM and datapath advance only when high
//   start         request, accepted when start && ce in IDLE
//   a, b          signed QFRAC dividend / divisor, sampled on accept
//   busy          high from the cycle after accept until valid
//   valid         one-cycle completion pulse
//   result        signed QFRAC quotient, held until the next valid
//   div_by_zero   qualified by valid: b was zero
// Build option: define DIV_SATURATE_EN to clamp overflowing quotients to the
// signed limits; otherwise the low M bits of the quotient are returned (wrap).
module fixed_divider
  import fixed_div_pkg::*;
#(
  parameter int M    = M_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         valid,
  output logic [M-1:0] result,
  output logic         div_by_zero
);

  localparam int QW = M + FRAC;
  localparam int CW = $clog2(QW);

  localparam logic [M-1:0]  SAT_POS = {1'b0, {(M-1){1'b1}}};
  localparam logic [M-1:0]  SAT_NEG = {1'b1, {(M-1){1'b0}}};
  localparam logic [M-1:0]  ONE_M   = {{(M-1){1'b0}}, 1'b1};
  localparam logic [QW:0]   ONE_Q   = {{QW{1'b0}}, 1'b1};

`ifdef DIV_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_e       state_r;
  logic         sa_r;
  logic         sb_r;
  logic         busy_r;
  logic         valid_r;
  logic [M-1:0] result_r;
  logic         dbz_r;

  logic [M-1:0]    a_mag_s;
  logic [M-1:0]    b_mag_s;
  logic            b_zero_s;
  logic [QW-1:0]   dividend_s;
  logic            accept_s;
  logic            load_s;
  logic            step_s;
  logic [QW-1:0]   core_q_s;
  logic            core_last_s;

  logic            neg_s;
  logic [QW:0]     q_ext_s;
  logic [QW:0]     q_sgn_s;
  logic [QW-M+1:0] hi_s;
  logic            ovf_s;
  logic [M-1:0]    fix_res_s;

  // Operand magnitudes; negating -2^(M-1) yields 2^(M-1) as an unsigned value.
  always_comb begin
    if (a[M-1]) begin
      a_mag_s = ~a + ONE_M;
    end else begin
      a_mag_s = a;
    end
    if (b[M-1]) begin
      b_mag_s = ~b + ONE_M;
    end else begin
      b_mag_s = b;
    end
    b_zero_s   = (b == {M{1'b0}});
    dividend_s = QW'(a_mag_s) << FRAC;
  end

  // Handshake decode: accept only in IDLE, step the core only in CALC.
  always_comb begin
    accept_s = ce && start && (state_r == ST_IDLE);
    load_s   = accept_s && !b_zero_s;
    step_s   = ce && (state_r == ST_CALC);
  end

  div_core #(
    .M     (M),
    .N     (QW),
    .CNT_W (CW)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .step     (step_s),
    .dividend (dividend_s),
    .divisor  (b_mag_s),
    .quotient (core_q_s),
    .last     (core_last_s)
  );

  // Sign restore and overflow check: the quotient is widened by one bit so a
  // magnitude with its top bit set is still read as positive before negation.
  always_comb begin
    neg_s   = sa_r ^ sb_r;
    q_ext_s = {1'b0, core_q_s};
    if (neg_s) begin
      q_sgn_s = ~q_ext_s + ONE_Q;
    end else begin
      q_sgn_s = q_ext_s;
    end
    hi_s = q_sgn_s[QW:M-1];
    if ((&hi_s) || !(|hi_s)) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = 1'b1;
    end
    if (SAT_EN && ovf_s) begin
      fix_res_s = neg_s ? SAT_NEG : SAT_POS;
    end else begin
      fix_res_s = q_sgn_s[M-1:0];
    end
  end

  // Control FSM and output registers; valid is a single pulse and never
  // repeats while ce is low because it is cleared on every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      result_r <= {M{1'b0}};
      dbz_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (ce) begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              sa_r    <= a[M-1];
              sb_r    <= b[M-1];
              busy_r  <= 1'b1;
              state_r <= b_zero_s ? ST_ZERO : ST_CALC;
            end
          end
          ST_CALC: begin
            if (core_last_s) begin
              state_r <= ST_FIX;
            end
          end
          ST_FIX: begin
            result_r <= fix_res_s;
            dbz_r    <= 1'b0;
            valid_r  <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
          ST_ZERO: begin
            result_r <= sa_r ? SAT_NEG : SAT_POS;
            dbz_r    <= 1'b1;
            valid_r  <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy        = busy_r;
  assign valid       = valid_r;
  assign result      = result_r;
  assign div_by_zero = dbz_r;

endmodule
